// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: aligns stores, holds the data-memory request until resp_b, extends loads.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and report through the misaligned port.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        read_b,
    output logic        write,
    output logic [3:0]  wmask,
    output logic [31:0] address_b,
    output logic [31:0] wdata,
    input  logic        resp_b,
    input  logic [31:0] rdata_b
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic        r_is_store;

    logic        w_accept;
    logic        w_size_b;
    logic        w_size_h;
    logic        w_misalign;
    logic [3:0]  w_store_mask;
    logic [31:0] w_store_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    assign w_accept = (r_state == S_IDLE) && req_valid && (req_load || req_store);
    assign stall    = w_accept || (r_state == S_WAIT);

    // funct3[1:0] selects the width; 011/110/111 fall through to word
    assign w_size_b = (funct3[1:0] == 2'b00);
    assign w_size_h = (funct3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (w_size_h && addr[0]) || (!w_size_b && !w_size_h && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_store_mask = 4'b1111;
        w_store_data = store_data;
        if (w_size_b) begin
            w_store_mask = 4'b0001 << addr[1:0];
            w_store_data = {4{store_data[7:0]}};
        end else if (w_size_h) begin
            w_store_mask = 4'b0011 << {addr[1], 1'b0};
            w_store_data = {2{store_data[15:0]}};
        end
    end

    // Lane extraction from the registered offset; misaligned halfwords use the lane of addr[1]
    always_comb begin
        w_byte = rdata_b[7:0];
        case (r_off)
            2'd1:    w_byte = rdata_b[15:8];
            2'd2:    w_byte = rdata_b[23:16];
            2'd3:    w_byte = rdata_b[31:24];
            default: w_byte = rdata_b[7:0];
        endcase
        w_half = r_off[1] ? rdata_b[31:16] : rdata_b[15:0];
        w_load_ext = rdata_b;
        if (r_funct3[1:0] == 2'b00) begin
            w_load_ext = r_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        end else if (r_funct3[1:0] == 2'b01) begin
            w_load_ext = r_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = w_misalign ? S_DONE : S_WAIT;
            S_WAIT:  if (resp_b) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Registered memory port and completion outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            read_b     <= 1'b0;
            write      <= 1'b0;
            wmask      <= 4'd0;
            address_b  <= 32'd0;
            wdata      <= 32'd0;
            done       <= 1'b0;
            load_data  <= 32'd0;
            r_funct3   <= 3'd0;
            r_off      <= 2'd0;
            r_is_store <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3   <= funct3;
                        r_off      <= addr[1:0];
                        r_is_store <= req_store;
                        if (w_misalign) begin
                            done      <= 1'b1;
                            load_data <= 32'd0;
`ifdef MISALIGN_TRAP_EN
                            misaligned <= 1'b1;
`endif
                        end else begin
                            read_b    <= !req_store;
                            write     <= req_store;
                            address_b <= {addr[31:2], 2'b00};
                            wmask     <= req_store ? w_store_mask : 4'd0;
                            wdata     <= req_store ? w_store_data : 32'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (resp_b) begin
                        read_b    <= 1'b0;
                        write     <= 1'b0;
                        wmask     <= 4'd0;
                        done      <= 1'b1;
                        load_data <= r_is_store ? 32'd0 : w_load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized transactions against an arithmetic model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_load, req_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, done;
    logic [31:0] load_data;
    logic        read_b, write;
    logic [3:0]  wmask;
    logic [31:0] address_b, wdata;
    logic        resp_b;
    logic [31:0] rdata_b;
`ifdef MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .stall(stall), .done(done), .load_data(load_data),
        .read_b(read_b), .write(write), .wmask(wmask),
        .address_b(address_b), .wdata(wdata),
        .resp_b(resp_b), .rdata_b(rdata_b)
`ifdef MISALIGN_TRAP_EN
        , .misaligned(misaligned)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit exp_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return size_of(f3) > 1 && (a % size_of(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int sz = size_of(f3);
        int lane = (a % 4) / sz;
        logic [31:0] v;
        if (sz == 1) begin
            v = (rd >> (8 * lane)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2) begin
            v = (rd >> (16 * lane)) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        int lane = (a % 4) / sz;
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << (sz * lane));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int sz = size_of(f3);
        if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    // One full transaction; the request stays asserted through DONE and must not be re-accepted
    task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int waits, input logic [31:0] rd, input bit stray);
        bit is_st = st;
        bit mis = exp_mis(f3, a);
        req_valid = 1'b1; req_load = ld; req_store = st;
        funct3 = f3; addr = a; store_data = sd;
        #1 check("stall_accept", 32'(stall), 32'd1);
        @(posedge clk); #1;
        if (!mis) begin
            for (int w = 0; w <= waits; w++) begin
                check("stall_wait", 32'(stall), 32'd1);
                check("done_wait", 32'(done), 32'd0);
                check("read_b", 32'(read_b), 32'(!is_st));
                check("write", 32'(write), 32'(is_st));
                check("address_b", address_b, a & 32'hFFFF_FFFC);
                check("wmask", 32'(wmask), is_st ? 32'(exp_mask(f3, a)) : 32'd0);
                if (is_st) check("wdata", wdata, exp_wdata(f3, sd));
                if (w == waits) begin
                    resp_b = 1'b1;
                    rdata_b = rd;
                end
                @(posedge clk); #1;
                resp_b = 1'b0;
                rdata_b = $urandom;
            end
        end else begin
            check("mis_read_b", 32'(read_b), 32'd0);
            check("mis_write", 32'(write), 32'd0);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("stall_done", 32'(stall), 32'd0);
        check("load_data", load_data, (is_st || mis) ? 32'd0 : exp_load(f3, a, rd));
        check("read_b_done", 32'(read_b), 32'd0);
        check("write_done", 32'(write), 32'd0);
`ifdef MISALIGN_TRAP_EN
        check("misaligned", 32'(misaligned), 32'(mis));
`endif
        @(posedge clk); #1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        check("done_single", 32'(done), 32'd0);
        check("no_reaccept_rd", 32'(read_b), 32'd0);
        check("no_reaccept_wr", 32'(write), 32'd0);
`ifdef MISALIGN_TRAP_EN
        check("misaligned_clr", 32'(misaligned), 32'd0);
`endif
        if (stray) begin
            resp_b = 1'b1;
            @(posedge clk); #1;
            resp_b = 1'b0;
            check("stray_resp_idle", 32'(done), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; resp_b = 1'b0; rdata_b = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_done", 32'(done), 32'd0);
        check("rst_read_b", 32'(read_b), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_wmask", 32'(wmask), 32'd0);
        check("rst_address_b", address_b, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
`ifdef MISALIGN_TRAP_EN
        check("rst_misaligned", 32'(misaligned), 32'd0);
`endif

        // Directed cases
        run_txn(1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 2, 32'd0, 1'b1);
        run_txn(1'b0, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 0, 32'd0, 1'b0);
        run_txn(1'b1, 1'b0, 3'b000, 32'h0000_3001, 32'h0, 0, 32'h1234_8000, 1'b0);
        run_txn(1'b1, 1'b0, 3'b100, 32'h0000_3001, 32'h0, 1, 32'h1234_8000, 1'b0);
        run_txn(1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'h0, 0, 32'hBEEF_0000, 1'b0);
        run_txn(1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'h0, 0, 32'hBEEF_0000, 1'b0);
        run_txn(1'b1, 1'b1, 3'b001, 32'h0000_4006, 32'h1234_5678, 0, 32'h0, 1'b0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
        run_txn(1'b1, 1'b0, 3'b111, 32'h0000_0010, 32'h0, 0, 32'h8765_4321, 1'b0);

        // Reset in WAIT, then a late response that must be ignored
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0100;
        @(posedge clk); #1;
        check("rstw_read_b_pre", 32'(read_b), 32'd1);
        rst = 1'b1; req_valid = 1'b0; req_load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstw_read_b", 32'(read_b), 32'd0);
        check("rstw_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        resp_b = 1'b1;
        @(posedge clk); #1;
        resp_b = 1'b0;
        check("rstw_no_done", 32'(done), 32'd0);
        check("rstw_read_b_post", 32'(read_b), 32'd0);
        @(posedge clk); #1;
        check("rstw_no_done2", 32'(done), 32'd0);

        // Randomized transactions
        for (int i = 0; i < 150; i++) begin
            bit st = 1'($urandom_range(0, 1));
            bit ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom,
                    int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store unit of the RV32IM pipeline; drives the data-memory port (read_b/write/wmask/address_b/wdata, resp_b/rdata_b) that the bench memory serves.
- Aligns store data and byte masks, holds the request until the memory responds, then extracts and sign/zero-extends load data.
- Stalls the pipeline for the whole transaction.

Parameters:
- (none)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM stage holds a valid instruction
- req_load  in  1  instruction is a load
- req_store  in  1  instruction is a store
- funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective byte address
- store_data  in  32  rs2 value, unshifted
- stall  out  1  hold all pipeline registers
- done  out  1  one-cycle pulse: transaction complete
- load_data  out  32  extended load result, valid while done=1
- read_b  out  1  data-memory read request
- write  out  1  data-memory write request
- wmask  out  4  byte enables for write
- address_b  out  32  word-aligned address
- wdata  out  32  lane-shifted store data
- resp_b  in  1  memory response, single-cycle pulse
- rdata_b  in  32  read data, valid with resp_b
- misaligned  out  1  present only with MISALIGN_TRAP_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states:
  - IDLE: accepts a request when req_valid & (req_load | req_store). It registers op, funct3, addr[1:0] and shifted data, then goes to WAIT.
  - WAIT: holds read_b or write, address_b, wmask and wdata stable until resp_b=1. On resp_b it captures rdata_b and goes to DONE.
  - DONE: lasts exactly one cycle. done=1, stall=0, load_data valid. Always returns to IDLE. Request inputs seen in DONE are ignored, because they still belong to the old instruction.
- Memory outputs are registered and first asserted the cycle after acceptance. read_b and write are never high together.
- stall (combinational) = (IDLE & req_valid & (req_load | req_store)) | WAIT.
- Minimum latency: accept → request 1 cycle later → DONE 1 cycle after resp_b. The total is 3 cycles with a zero-wait memory.
- If req_load and req_store are both high, the store wins.
- funct3 011, 110 or 111 is treated as a word access.
- address_b = {addr[31:2], 2'b00}.
- Stores:
  - SB: wmask = 4'b0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: wmask = 4'b0011 << {addr[1], 1'b0}; wdata = {2{store_data[15:0]}}.
  - SW: wmask = 4'b1111; wdata = store_data.
  - wmask = 0 for loads.
- Loads: the byte lane is selected by addr[1:0], the halfword lane by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata_b.
  - load_data is 0 for stores.
- resp_b seen in IDLE or DONE is ignored.
- Reset values: state IDLE; read_b, write, done and misaligned = 0; wmask = 0; address_b, wdata and load_data = 0.
- Reset mid-transaction forces IDLE and drops read_b/write on the same edge. A later stray resp_b is ignored.
- Without the trap feature, misaligned addresses are silently forced into alignment: H ignores addr[0]; W ignores addr[1:0].

Optional Feature:
- Macro: MISALIGN_TRAP_EN
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, issues no memory request.
  - The FSM goes IDLE→DONE directly: stall for 1 cycle, then done=1, misaligned=1, load_data=0.
  - misaligned is 0 in every other cycle.
- Undefined:
  - The misaligned port is absent.
  - Addresses are forced into alignment as described under Behaviour.

Test Plan:
- SW addr=0x0000_1004, data=0xDEADBEEF, resp after 2 wait cycles → write=1 and wmask=1111 for 3 cycles; address_b=0x1004; stall high until DONE; single done pulse.
- SB addr=0x0000_2003, data=0x0000_00A5 → wmask=1000, wdata=0xA5A5A5A5, address_b=0x2000.
- LB addr=0x0000_3001, rdata_b=0x1234_8000 → load_data=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- LHU addr=0x0000_3002, rdata_b=0xBEEF_0000 → load_data=0x0000_BEEF. LH → 0xFFFF_BEEF.
- rst asserted in WAIT, then resp_b pulses 2 cycles later → read_b=0 after the reset edge; no done pulse; state IDLE.
- (MISALIGN_TRAP_EN) LW addr=0x0000_0006 → read_b never asserted; done=1 and misaligned=1 in the 2nd cycle; load_data=0.
